bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq_pkg.sv | 13 +
 rtl/bin2bcd_seq_dabble_adjust.sv | 7 +
 rtl/bin2bcd_seq.sv | 106 ++++++++++
 tb/tb_bin2bcd_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
// BCD_DIGITS is also consumed by the seven-segment display driver.
package bin2bcd_seq_pkg;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int MAX_DEC    = 9999;
  localparam int BIN_W_DEF  = 14;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/bin2bcd_seq_dabble_adjust.sv
// One double-dabble correction step for a single BCD nibble: add 3 when >= 5.
module dabble_adjust (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Result digits are registered and only change in the Done cycle.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [3:0]       o_bcd3,
  output logic [3:0]       o_bcd2,
  output logic [3:0]       o_bcd1,
  output logic [3:0]       o_bcd0,
  output state_e           o_state
);
  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_DEC);

  state_e                   r_state;
  state_e                   w_next;
  logic [BCD_W-1:0]         r_bcd;
  logic [BIN_W-1:0]         r_bin;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_ovf_pend;
  logic                     r_done;
  logic                     r_ovf;
  logic [BCD_W-1:0]         r_digits;
  logic [BCD_W-1:0]         w_bcd_adj;
  logic [BCD_W+BIN_W-1:0]   w_sh;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_ovf_in;
  logic [BIN_W-1:0]         w_sat;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    dabble_adjust u_adj (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  // Adjusted BCD and remaining binary move left together as one register.
  assign w_sh     = {w_bcd_adj, r_bin} << 1;
  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_ovf_in = (i_bin > MAX_BIN);
  assign w_sat    = w_ovf_in ? MAX_BIN : i_bin;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last)  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_digits   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin      <= w_sat;
        r_bcd      <= '0;
        r_ovf_pend <= w_ovf_in;
        r_cnt      <= CNT_W'(BIN_W);
      end else if (r_state == ST_SHIFT) begin
        r_bcd <= w_sh[BCD_W+BIN_W-1:BIN_W];
        r_bin <= w_sh[BIN_W-1:0];
        r_cnt <= r_cnt - CNT_W'(1);
        // Final shift goes straight to the display registers.
        if (w_last) begin
          r_digits <= w_sh[BCD_W+BIN_W-1:BIN_W];
          r_ovf    <= r_ovf_pend;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = (r_state == ST_SHIFT);
  assign o_done     = r_done;
  assign o_overflow = r_ovf;
  assign o_bcd3     = r_digits[15:12];
  assign o_bcd2     = r_digits[11:8];
  assign o_bcd1     = r_digits[7:4];
  assign o_bcd0     = r_digits[3:0];
  assign o_state    = r_state;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected {overflow, digits}
// popped on every Done pulse, plus per-scenario timing and hold checks.
module tb_bin2bcd_seq;
  import bin2bcd_seq_pkg::*;

  localparam int BIN_W = 14;

  logic             clk;
  logic             i_reset;
  logic             i_start;
  logic [BIN_W-1:0] i_bin;
  logic             o_busy;
  logic             o_done;
  logic             o_overflow;
  logic [3:0]       o_bcd3, o_bcd2, o_bcd1, o_bcd0;
  state_e           o_state;

  logic [16:0] exp_q[$];
  logic [16:0] hold_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_dones  = 0;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_bcd3     (o_bcd3),
    .o_bcd2     (o_bcd2),
    .o_bcd1     (o_bcd1),
    .o_bcd0     (o_bcd0),
    .o_state    (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] model(input int b);
    int s;
    s = (b > 9999) ? 9999 : b;
    return {(b > 9999), 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] got_out();
    return {o_overflow, o_bcd3, o_bcd2, o_bcd1, o_bcd0};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (i_reset === 1'b1 && o_done === 1'b1) begin
      logic [16:0] e;
      n_dones++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL done_unexpected: got %h, expected no Done", got_out());
      end else begin
        e = exp_q.pop_front();
        if (got_out() !== e) begin
          n_errors++;
          $display("FAIL result: got ovf/digits %h, expected %h", got_out(), e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    i_reset = 1'b0; i_start = 1'b0; i_bin = '0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (got_out() !== 17'h0) begin
      n_errors++; $display("FAIL reset_outputs: got %h, expected 0", got_out());
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got busy=%b done=%b, expected 0 0", o_busy, o_done);
    end
    hold_exp = '0;
  endtask

  task automatic run_one(input int b);
    logic [16:0] e;
    int busy_cyc;
    e = model(b);
    exp_q.push_back(e);
    i_bin = BIN_W'(b); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_bin = BIN_W'($urandom_range(0, 16383));
    busy_cyc = 0;
    while (o_done !== 1'b1 && busy_cyc < 40) begin
      n_checks++;
      if (o_busy !== 1'b1 || got_out() !== hold_exp) begin
        n_errors++;
        $display("FAIL hold_%0d: got busy=%b out=%h, expected busy=1 out=%h", b, o_busy, got_out(), hold_exp);
      end
      busy_cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (o_done !== 1'b1) begin
      n_errors++; $display("FAIL timeout_%0d: got no Done, expected Done", b);
    end else if (busy_cyc != 14 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL latency_%0d: got %0d busy cycles busy_at_done=%b, expected 14 and 0", b, busy_cyc, o_busy);
    end
    hold_exp = e;
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0) begin
      n_errors++; $display("FAIL done_width_%0d: got done=%b, expected 0", b, o_done);
    end
  endtask

  task automatic test_values();
    run_one(1234);
    run_one(9999);
    run_one(12000);
    run_one(0);
    run_one(16383);
    run_one(10000);
    for (int i = 0; i < 4; i++) run_one($urandom_range(0, 16383));
  endtask

  task automatic test_start_ignored();
    int d0, guard;
    d0 = n_dones;
    exp_q.push_back(model(56));
    i_bin = 14'd56; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_bin = 14'd7; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    guard = 0;
    while (o_done !== 1'b1 && guard < 40) begin guard++; @(negedge clk); end
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_dones - d0 != 1) begin
      n_errors++; $display("FAIL start_ignored: got %0d Done pulses, expected 1", n_dones - d0);
    end
    hold_exp = model(56);
  endtask

  task automatic test_reset_mid();
    int d0;
    i_bin = 14'd4321; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || got_out() !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_mid: got busy=%b done=%b out=%h, expected 0 0 0", o_busy, o_done, got_out());
    end
    i_reset = 1'b1;
    hold_exp = '0;
    d0 = n_dones;
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_dones != d0) begin
      n_errors++; $display("FAIL reset_no_done: got %0d Done pulses, expected 0", n_dones - d0);
    end
  endtask

  task automatic test_back_to_back();
    int k, t0, t1, t2, cyc;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(42));
    i_bin = 14'd42; i_start = 1'b1;
    k = 0; cyc = 0; t0 = 0; t1 = 0; t2 = 0;
    while (k < 3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      n_checks++;
      if (o_busy !== ~o_done) begin
        n_errors++; $display("FAIL b2b_busy: got busy=%b done=%b at cycle %0d, expected busy=~done", o_busy, o_done, cyc);
      end
      if (o_done === 1'b1) begin
        if (k == 0) t0 = cyc; else if (k == 1) t1 = cyc; else t2 = cyc;
        k++;
      end
    end
    i_start = 1'b0;
    n_checks++;
    if (k != 3 || t1 - t0 != 15 || t2 - t1 != 15) begin
      n_errors++; $display("FAIL b2b_period: got %0d pulses spaced %0d/%0d, expected 3 spaced 15/15", k, t1 - t0, t2 - t1);
    end
    hold_exp = model(42);
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_stop: got busy=%b, expected 0", o_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_values();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (20) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
